// File: rtl/pipe_hazard_ctrl_if.sv
// Split I-cache / D-cache request-response handshake seen by the pipeline controller.
// master drives requests and responses; slave (the controller) returns the gated enables.
interface pipe_hazard_ctrl_if;
  logic imem_req;
  logic imem_resp;
  logic imem_read_en;
  logic dmem_req;
  logic dmem_resp;
  logic dmem_en;

  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp,
    input  imem_read_en, dmem_en
  );

  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp,
    output imem_read_en, dmem_en
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline load/flush/PC control for the RV32I core: cache stalls, EX redirects, load-use bubbles.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned BRANCH_STAGE = 2,
  parameter int unsigned REG_IDX_W    = 5,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    mem,
  input  logic                 branch_taken,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  output logic                 pc_load,
  output logic [NUM_REGS-1:0]  stage_load,
  output logic [NUM_REGS-1:0]  stage_flush,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [NUM_REGS-1:0] BRANCH_MASK = NUM_REGS'((64'd1 << BRANCH_STAGE) - 64'd1);

  if (BRANCH_STAGE < 1 || BRANCH_STAGE >= NUM_REGS) begin : g_bad_branch_stage
    $error("pipe_hazard_ctrl: BRANCH_STAGE must be in 1..NUM_REGS-1");
  end

  logic i_done;
  logic d_done;
  logic hazard;
  logic mem_stall;

  // Load-use: the instruction in IF/ID reads the register a load in ID/EX is about to write.
  always_comb begin
    hazard = ex_is_load && (ex_rd != '0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    mem_stall = (mem.imem_req && !mem.imem_resp && !i_done) ||
                (mem.dmem_req && !mem.dmem_resp && !d_done);
  end

  // A cache that already answered during this stall is masked from further requests.
  always_comb begin
    mem.imem_read_en = 1'b0;
    mem.dmem_en      = 1'b0;
    pc_load          = 1'b0;
    stage_load       = '0;
    stage_flush      = '0;
    if (reset) begin
      stage_load  = '1;
      stage_flush = '1;
    end else begin
      mem.imem_read_en = mem.imem_req && !i_done;
      mem.dmem_en      = mem.dmem_req && !d_done;
      if (mem_stall) begin
        pc_load = 1'b0;
      end else if (branch_taken) begin
        pc_load     = 1'b1;
        stage_load  = '1;
        stage_flush = BRANCH_MASK;
      end else if (hazard) begin
        stage_load     = '1;
        stage_load[0]  = 1'b0;
        stage_flush[1] = 1'b1;
      end else begin
        pc_load    = 1'b1;
        stage_load = '1;
      end
    end
  end

  // Response flags accumulate while frozen and drop as soon as the pipe advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (mem_stall) begin
      i_done <= i_done || (mem.imem_req && mem.imem_resp);
      d_done <= d_done || (mem.dmem_req && mem.dmem_resp);
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating event counters; a redirect or bubble counts only on the cycle it is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      bubble_cnt   <= '0;
      flush_cnt    <= '0;
    end else begin
      if (mem_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (!mem_stall && !branch_taken && hazard && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      if (!mem_stall && branch_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  always_comb begin
    stall_cycles = '0;
    bubble_cnt   = '0;
    flush_cnt    = '0;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (default parameters, 4 pipe registers, BRANCH_STAGE 2).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       branch_taken, ex_is_load, id_use_rs1, id_use_rs2;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       pc_load;
  logic [3:0] stage_load, stage_flush;
  logic [31:0] stall_cycles, bubble_cnt, flush_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl_if mif ();

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (mif.slave),
    .branch_taken (branch_taken),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .pc_load      (pc_load),
    .stage_load   (stage_load),
    .stage_flush  (stage_flush),
    .stall_cycles (stall_cycles),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, ireq, iresp, dreq, dresp, br, ld, u1, u2;
    logic [4:0] rd, rs1, rs2;
    logic       e_pc;
    logic [3:0] e_load, e_flush;
    logic       e_ire, e_de;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic rst, logic ireq, logic iresp, logic dreq,
                              logic dresp, logic br, logic ld, logic [4:0] rd,
                              logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic e_pc, logic [3:0] e_load, logic [3:0] e_flush,
                              logic e_ire, logic e_de);
    vec_t v;
    v.name = name; v.rst = rst; v.ireq = ireq; v.iresp = iresp; v.dreq = dreq;
    v.dresp = dresp; v.br = br; v.ld = ld; v.rd = rd; v.rs1 = rs1; v.u1 = u1;
    v.rs2 = rs2; v.u2 = u2; v.e_pc = e_pc; v.e_load = e_load; v.e_flush = e_flush;
    v.e_ire = e_ire; v.e_de = e_de;
    return v;
  endfunction

  // Drive one cycle, compare at the falling edge, then let the rising edge update state.
  task automatic apply(input vec_t v);
    logic [10:0] got, exp;
    reset = v.rst; mif.imem_req = v.ireq; mif.imem_resp = v.iresp;
    mif.dmem_req = v.dreq; mif.dmem_resp = v.dresp; branch_taken = v.br;
    ex_is_load = v.ld; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    @(negedge clk);
    got = {pc_load, stage_load, stage_flush, mif.imem_read_en, mif.dmem_en};
    exp = {v.e_pc, v.e_load, v.e_flush, v.e_ire, v.e_de};
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%b load=%b flush=%b ire=%b de=%b, want pc=%b load=%b flush=%b ire=%b de=%b",
               v.name, got[10], got[9:6], got[5:2], got[1], got[0],
               exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name, input int es, input int eb, input int ef);
    n_vec++;
    if (stall_cycles !== 32'(es) || bubble_cnt !== 32'(eb) || flush_cnt !== 32'(ef)) begin
      n_fail++;
      $display("FAIL %s: got stall=%0d bubble=%0d flush=%0d, want stall=%0d bubble=%0d flush=%0d",
               name, stall_cycles, bubble_cnt, flush_cnt, es, eb, ef);
    end
  endtask

  // Shorthand vectors: cache-only, and pipeline-only with caches idle.
  function automatic vec_t mc(string n, logic rst, logic ireq, logic iresp, logic dreq,
                              logic dresp, logic br, logic e_pc, logic [3:0] e_load,
                              logic [3:0] e_flush, logic e_ire, logic e_de);
    return mk(n, rst, ireq, iresp, dreq, dresp, br, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
              e_pc, e_load, e_flush, e_ire, e_de);
  endfunction

  int stall_exp;

  initial begin
    reset = 1'b1; mif.imem_req = 1'b0; mif.imem_resp = 1'b0; mif.dmem_req = 1'b0;
    mif.dmem_resp = 1'b0; branch_taken = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    @(posedge clk); #1;

    // name, rst, ireq, iresp, dreq, dresp, br -> pc, load, flush, ire, de
    tbl.push_back(mc("reset",        1, 1, 0, 1, 0, 0, 0, 4'b1111, 4'b1111, 0, 0));
    tbl.push_back(mc("idle",         0, 0, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0));
    tbl.push_back(mc("t1_wait0",     0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mc("t1_wait1",     0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mc("t1_wait2",     0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mc("t1_resp",      0, 1, 1, 0, 0, 0, 1, 4'b1111, 4'b0000, 1, 0));
    tbl.push_back(mc("zero_lat",     0, 1, 1, 0, 0, 0, 1, 4'b1111, 4'b0000, 1, 0));
    tbl.push_back(mc("resp_noreq",   0, 0, 1, 0, 1, 0, 1, 4'b1111, 4'b0000, 0, 0));
    tbl.push_back(mc("after_noreq",  0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mc("both_resp",    0, 1, 1, 1, 1, 0, 1, 4'b1111, 4'b0000, 1, 1));
    tbl.push_back(mc("both_again",   0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mc("both_resp2",   0, 1, 1, 1, 1, 0, 1, 4'b1111, 4'b0000, 1, 1));
    tbl.push_back(mc("t2_c0",        0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mc("t2_c1",        0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mc("t2_c2_iresp",  0, 1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mc("t2_c3",        0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1));
    tbl.push_back(mc("t2_c4",        0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1));
    tbl.push_back(mc("t2_c5_dresp",  0, 1, 0, 1, 1, 0, 1, 4'b1111, 4'b0000, 0, 1));
    tbl.push_back(mc("t2_flags_clr", 0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mc("t2_end",       0, 1, 1, 0, 0, 0, 1, 4'b1111, 4'b0000, 1, 0));
    // name, rst, ireq, iresp, dreq, dresp, br, ld, rd, rs1, u1, rs2, u2 -> expected
    tbl.push_back(mk("t3_hazard_rs2", 0, 0,0,0,0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1, 0, 4'b1110, 4'b0010, 0, 0));
    tbl.push_back(mk("t3_next",       0, 0,0,0,0, 0, 0, 5'd5, 5'd1, 1, 5'd5, 1, 1, 4'b1111, 4'b0000, 0, 0));
    tbl.push_back(mk("haz_rd0",       0, 0,0,0,0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 1, 4'b1111, 4'b0000, 0, 0));
    tbl.push_back(mk("haz_unused",    0, 0,0,0,0, 0, 1, 5'd5, 5'd5, 0, 5'd5, 0, 1, 4'b1111, 4'b0000, 0, 0));
    tbl.push_back(mk("haz_rs1",       0, 0,0,0,0, 0, 1, 5'd7, 5'd7, 1, 5'd2, 1, 0, 4'b1110, 4'b0010, 0, 0));
    tbl.push_back(mk("t4_br_haz",     0, 0,0,0,0, 1, 1, 5'd5, 5'd1, 0, 5'd5, 1, 1, 4'b1111, 4'b0011, 0, 0));
    tbl.push_back(mk("br_only",       0, 0,0,0,0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 4'b1111, 4'b0011, 0, 0));
    tbl.push_back(mk("haz_in_stall",  0, 1,0,0,0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk("haz_after",     0, 1,1,0,0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 4'b1110, 4'b0010, 1, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Test 5: redirect held during a 4-cycle D stall is applied once on the response edge.
    for (int i = 0; i < 4; i++)
      apply(mc("t5_dstall",    0, 0, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 1));
    apply(mc("t5_dresp_br",    0, 0, 0, 1, 1, 1, 1, 4'b1111, 4'b0011, 0, 1));
    apply(mc("t5_after",       0, 0, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0));

    // Test 6: reset in the middle of a stall with i_done already set.
    apply(mc("t6_stall",       0, 1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    apply(mc("t6_idone",       0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1));
    apply(mc("t6_reset",       1, 1, 0, 1, 0, 0, 0, 4'b1111, 4'b1111, 0, 0));
    check_cnt("t6_cnt_reset", 0, 0, 0);
    apply(mc("t6_flags_gone",  0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));

    // Counter accumulation: 3 stalls, 1 bubble, 1 redirect after a fresh reset.
    apply(mc("pc_reset",       1, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b1111, 0, 0));
    for (int i = 0; i < 3; i++)
      apply(mc("pc_stall",     0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    apply(mc("pc_resp",        0, 1, 1, 0, 0, 0, 1, 4'b1111, 4'b0000, 1, 0));
    apply(mk("pc_bubble",      0, 0,0,0,0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 4'b1110, 4'b0010, 0, 0));
    apply(mc("pc_branch",      0, 0, 0, 0, 0, 1, 1, 4'b1111, 4'b0011, 0, 0));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    stall_exp = 3;
    check_cnt("perf_counts", stall_exp, 1, 1);
`else
    stall_exp = 0;
    check_cnt("perf_tied_off", stall_exp, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
